reg_read_stage: RTL and testbench
=================================

REG_READ_STAGE -- requirements
Module: reg_read_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits.
REQ-002 Parameter PRF_ENTRIES, default 64, number of physical registers; PREG_W = $clog2(PRF_ENTRIES).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fire_valid  input  1  scheduler issued an instruction this cycle.
REQ-006 sched_pkt  input  disp_packet_t  issued packet; fields prs1, prs2, prd, use_rs1, use_rs2, rs_entry.
REQ-007 flush  input  1  squash the instruction entering and the instruction held in this stage.
REQ-008 wb_valid  input  1  writeback port write enable.
REQ-009 wb_preg  input  PREG_W  writeback destination physical register.
REQ-010 wb_data  input  XLEN  writeback data.
REQ-011 ex_valid  output  1  operand packet to execute is valid.
REQ-012 ex_pkt  output  disp_packet_t  packet forwarded to execute.
REQ-013 ex_rs1_data  output  XLEN  source-1 operand.
REQ-014 ex_rs2_data  output  XLEN  source-2 operand.
REQ-015 bypass_count  output  16  saturating count of operands supplied by bypass.

Function
REQ-016 Stage SHALL hold a PRF_ENTRIES x XLEN physical register file with two combinational read ports and one write port.
REQ-017 Physical register 0 SHALL always read 0; writes to preg 0 SHALL be ignored.
REQ-018 When wb_valid is high, wb_data SHALL be written to wb_preg at the rising edge.
REQ-019 Latency SHALL be exactly one cycle: fire_valid/sched_pkt in cycle N appear as ex_valid/ex_pkt in cycle N+1.
REQ-020 No backpressure: a new instruction SHALL be accepted every cycle fire_valid is high.
REQ-021 Operand source priority per port: preg 0 -> zero; else wb_valid with wb_preg equal to the source preg -> wb_data (same-cycle bypass); else PRF contents.
REQ-022 A source with use_rsN low SHALL drive ex_rsN_data to 0 and SHALL NOT count as a bypass.
REQ-023 Operands SHALL be captured into the pipeline register in cycle N; a writeback in cycle N+1 SHALL NOT alter ex_rsN_data.
REQ-024 When fire_valid is low, ex_valid SHALL drop to 0 next cycle; ex_pkt and operand registers SHALL hold their previous values.
REQ-025 flush high in cycle N SHALL force ex_valid to 0 in cycle N+1 regardless of fire_valid; the PRF write in cycle N SHALL still occur.
REQ-026 bypass_count SHALL increment by the number of bypassed operands (0, 1 or 2) per accepted, unflushed instruction and saturate at 16'hFFFF.
REQ-027 Both ports reading the same preg SHALL return identical data.

Reset
REQ-028 On rst: ex_valid = 0, ex_pkt = '0, ex_rs1_data = 0, ex_rs2_data = 0, bypass_count = 0, all PRF entries = 0.
REQ-029 rst SHALL take precedence over fire_valid, flush and wb_valid in the same cycle; in-flight instruction SHALL be dropped.

Structure
REQ-030 XLEN, PRF_ENTRIES, PREG_W and disp_packet_t SHALL reside in the shared core package; no local typedefs.
REQ-031 Sub-module prf (2R/1W register file with zero register) SHALL be instantiated once; bypass muxing and pipeline register SHALL live in reg_read_stage.

Verification
REQ-032 Write preg 5 = 0xDEAD_BEEF; next cycle fire prs1=5, use_rs1=1 -> next cycle ex_valid=1, ex_rs1_data=0xDEAD_BEEF, bypass_count unchanged.
REQ-033 Same cycle wb_valid, wb_preg=7, wb_data=0x1234 and fire prs1=7, prs2=7 -> both operands 0x1234, bypass_count +2.
REQ-034 Write preg 0 = 0xFFFF_FFFF, then fire prs1=0 -> ex_rs1_data=0, no bypass counted.
REQ-035 fire_valid and flush both high -> ex_valid=0 next cycle; back-to-back fires over 4 cycles without flush -> ex_valid=1 each following cycle, packets in order.
REQ-036 Preload bypass_count to 0xFFFE via 0xFFFE single bypasses, then one double bypass -> bypass_count=0xFFFF and holds.
REQ-037 rst asserted with fire_valid high -> ex_valid=0, all outputs 0 next cycle; fire prs1=5 after reset -> ex_rs1_data=0.

Source files
------------

// File: rtl/reg_read_stage_pkg.sv
// rtl/reg_read_stage_pkg.sv - shared core types and sizes for the register read stage
package reg_read_stage_pkg;

  localparam int XLEN        = 32;
  localparam int PRF_ENTRIES = 64;
  localparam int PREG_W      = $clog2(PRF_ENTRIES);
  localparam int RS_ENTRY_W  = 4;

  typedef struct packed {
    logic [PREG_W-1:0]     prs1;
    logic [PREG_W-1:0]     prs2;
    logic [PREG_W-1:0]     prd;
    logic                  use_rs1;
    logic                  use_rs2;
    logic [RS_ENTRY_W-1:0] rs_entry;
  } disp_packet_t;

endpackage

// File: rtl/reg_read_stage_prf.sv
// rtl/reg_read_stage_prf.sv - 2R/1W physical register file with hardwired zero register
module prf #(
  parameter int XLEN        = 32,
  parameter int PRF_ENTRIES = 64,
  parameter int PREG_W      = $clog2(PRF_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PREG_W-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [PREG_W-1:0] raddr1,
  output logic [XLEN-1:0]   rdata1,
  input  logic [PREG_W-1:0] raddr2,
  output logic [XLEN-1:0]   rdata2
);

  logic [XLEN-1:0] mem [PRF_ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PRF_ENTRIES; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/reg_read_stage.sv
// rtl/reg_read_stage.sv - operand read with same-cycle writeback bypass and one-cycle pipeline register
module reg_read_stage
  import reg_read_stage_pkg::*;
#(
  parameter int XLEN        = reg_read_stage_pkg::XLEN,
  parameter int PRF_ENTRIES = reg_read_stage_pkg::PRF_ENTRIES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fire_valid,
  input  disp_packet_t      sched_pkt,
  input  logic              flush,
  input  logic              wb_valid,
  input  logic [PREG_W-1:0] wb_preg,
  input  logic [XLEN-1:0]   wb_data,
  output logic              ex_valid,
  output disp_packet_t      ex_pkt,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [15:0]       bypass_count
);

  logic [XLEN-1:0] prf_rdata1, prf_rdata2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            rs1_byp, rs2_byp;
  logic [16:0]     count_sum;

  prf #(
    .XLEN       (XLEN),
    .PRF_ENTRIES(PRF_ENTRIES),
    .PREG_W     (PREG_W)
  ) u_prf (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_valid),
    .waddr (wb_preg),
    .wdata (wb_data),
    .raddr1(sched_pkt.prs1),
    .rdata1(prf_rdata1),
    .raddr2(sched_pkt.prs2),
    .rdata2(prf_rdata2)
  );

  // Zero register never bypasses, so a write to preg 0 cannot leak through.
  assign rs1_byp = sched_pkt.use_rs1 && (sched_pkt.prs1 != '0) && wb_valid && (wb_preg == sched_pkt.prs1);
  assign rs2_byp = sched_pkt.use_rs2 && (sched_pkt.prs2 != '0) && wb_valid && (wb_preg == sched_pkt.prs2);

  assign rs1_val = !sched_pkt.use_rs1 ? '0 : (rs1_byp ? wb_data : prf_rdata1);
  assign rs2_val = !sched_pkt.use_rs2 ? '0 : (rs2_byp ? wb_data : prf_rdata2);

  assign count_sum = {1'b0, bypass_count} + 17'(rs1_byp) + 17'(rs2_byp);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_pkt       <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      bypass_count <= '0;
    end else begin
      ex_valid <= fire_valid && !flush;
      if (fire_valid) begin
        ex_pkt      <= sched_pkt;
        ex_rs1_data <= rs1_val;
        ex_rs2_data <= rs2_val;
      end
      if (fire_valid && !flush) begin
        bypass_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
      end
    end
  end

endmodule

// File: tb/tb_reg_read_stage.sv
// tb/tb_reg_read_stage.sv - directed self-checking bench for reg_read_stage
module tb_reg_read_stage;
  import reg_read_stage_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              fire_valid;
  disp_packet_t      sched_pkt;
  logic              flush;
  logic              wb_valid;
  logic [PREG_W-1:0] wb_preg;
  logic [XLEN-1:0]   wb_data;
  logic              ex_valid;
  disp_packet_t      ex_pkt;
  logic [XLEN-1:0]   ex_rs1_data;
  logic [XLEN-1:0]   ex_rs2_data;
  logic [15:0]       bypass_count;

  int tests_run = 0;
  int tests_failed = 0;

  reg_read_stage dut (
    .clk         (clk),
    .rst         (rst),
    .fire_valid  (fire_valid),
    .sched_pkt   (sched_pkt),
    .flush       (flush),
    .wb_valid    (wb_valid),
    .wb_preg     (wb_preg),
    .wb_data     (wb_data),
    .ex_valid    (ex_valid),
    .ex_pkt      (ex_pkt),
    .ex_rs1_data (ex_rs1_data),
    .ex_rs2_data (ex_rs2_data),
    .bypass_count(bypass_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic disp_packet_t mk(input int p1, input int p2, input int pd,
                                      input bit u1, input bit u2, input int rse);
    disp_packet_t p;
    p.prs1     = PREG_W'(p1);
    p.prs2     = PREG_W'(p2);
    p.prd      = PREG_W'(pd);
    p.use_rs1  = u1;
    p.use_rs2  = u2;
    p.rs_entry = RS_ENTRY_W'(rse);
    return p;
  endfunction

  task automatic wb(input bit v, input int preg, input logic [XLEN-1:0] d);
    wb_valid = v;
    wb_preg  = PREG_W'(preg);
    wb_data  = d;
  endtask

  task automatic idle();
    fire_valid = 1'b0;
    flush      = 1'b0;
    wb(0, 0, '0);
  endtask

  initial begin
    disp_packet_t p;
    rst = 1'b1;
    sched_pkt = '0;
    idle();
    step();
    step();
    check("reset_valid", 64'(ex_valid), 64'd0);
    check("reset_pkt", 64'(ex_pkt), 64'd0);
    check("reset_rs1", 64'(ex_rs1_data), 64'd0);
    check("reset_rs2", 64'(ex_rs2_data), 64'd0);
    check("reset_count", 64'(bypass_count), 64'd0);
    rst = 1'b0;

    // PRF write then read next cycle: no bypass
    wb(1, 5, 32'hDEAD_BEEF);
    step();
    check("idle_valid", 64'(ex_valid), 64'd0);
    idle();
    p = mk(5, 0, 12, 1, 0, 3);
    fire_valid = 1'b1;
    sched_pkt  = p;
    step();
    check("prf_valid", 64'(ex_valid), 64'd1);
    check("prf_rs1", 64'(ex_rs1_data), 64'hDEAD_BEEF);
    check("prf_rs2_unused", 64'(ex_rs2_data), 64'd0);
    check("prf_pkt", 64'(ex_pkt), 64'(p));
    check("prf_count", 64'(bypass_count), 64'd0);

    // Same-cycle double bypass
    wb(1, 7, 32'h1234);
    sched_pkt = mk(7, 7, 8, 1, 1, 4);
    step();
    check("byp2_rs1", 64'(ex_rs1_data), 64'h1234);
    check("byp2_rs2", 64'(ex_rs2_data), 64'h1234);
    check("byp2_count", 64'(bypass_count), 64'd2);

    // Captured operand must not change under a later writeback
    wb(0, 0, '0);
    sched_pkt = mk(7, 5, 8, 1, 1, 5);
    step();
    check("hold_rs1_read", 64'(ex_rs1_data), 64'h1234);
    check("hold_rs2_read", 64'(ex_rs2_data), 64'hDEAD_BEEF);
    fire_valid = 1'b0;
    wb(1, 7, 32'h5555);
    step();
    check("hold_valid", 64'(ex_valid), 64'd0);
    check("hold_rs1", 64'(ex_rs1_data), 64'h1234);
    check("hold_pkt", 64'(ex_pkt), 64'(mk(7, 5, 8, 1, 1, 5)));
    check("hold_count", 64'(bypass_count), 64'd2);

    // Preg 0 stays zero, neither stored nor bypassed
    wb(1, 0, 32'hFFFF_FFFF);
    step();
    fire_valid = 1'b1;
    sched_pkt  = mk(0, 0, 1, 1, 1, 6);
    step();
    check("zero_rs1", 64'(ex_rs1_data), 64'd0);
    check("zero_rs2_byp", 64'(ex_rs2_data), 64'd0);
    check("zero_count", 64'(bypass_count), 64'd2);

    // Unused source with matching writeback: zero and not counted
    wb(1, 9, 32'hABCD);
    sched_pkt = mk(7, 9, 2, 1, 0, 7);
    step();
    check("unused_rs1", 64'(ex_rs1_data), 64'h5555);
    check("unused_rs2", 64'(ex_rs2_data), 64'd0);
    check("unused_count", 64'(bypass_count), 64'd2);

    // Flush squashes but the PRF write lands
    wb(1, 11, 32'hCAFE_0011);
    flush = 1'b1;
    sched_pkt = mk(11, 0, 2, 1, 0, 8);
    step();
    check("flush_valid", 64'(ex_valid), 64'd0);
    check("flush_count", 64'(bypass_count), 64'd2);
    flush = 1'b0;
    wb(0, 0, '0);
    sched_pkt = mk(11, 9, 2, 1, 1, 9);
    step();
    check("flush_wr_rs1", 64'(ex_rs1_data), 64'hCAFE_0011);
    check("flush_wr_rs2", 64'(ex_rs2_data), 64'hABCD);

    // Back-to-back fires arrive in order
    for (int i = 0; i < 4; i++) begin
      sched_pkt = mk(5, 11, i + 20, 1, 1, i + 10);
      step();
      check($sformatf("b2b_valid_%0d", i), 64'(ex_valid), 64'd1);
      check($sformatf("b2b_pkt_%0d", i), 64'(ex_pkt), 64'(mk(5, 11, i + 20, 1, 1, i + 10)));
    end

    // Saturation: 0xFFFE single bypasses then double bypasses
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wb(1, 3, 32'h33);
    fire_valid = 1'b1;
    sched_pkt  = mk(3, 0, 1, 1, 0, 1);
    repeat (16'hFFFE) step();
    check("sat_preload", 64'(bypass_count), 64'hFFFE);
    sched_pkt = mk(3, 3, 1, 1, 1, 1);
    step();
    check("sat_reach", 64'(bypass_count), 64'hFFFF);
    step();
    check("sat_hold", 64'(bypass_count), 64'hFFFF);

    // Reset wins over fire/flush/writeback
    rst = 1'b1;
    flush = 1'b1;
    wb(1, 5, 32'h7777);
    sched_pkt = mk(5, 5, 3, 1, 1, 2);
    step();
    check("rst_valid", 64'(ex_valid), 64'd0);
    check("rst_pkt", 64'(ex_pkt), 64'd0);
    check("rst_rs1", 64'(ex_rs1_data), 64'd0);
    check("rst_rs2", 64'(ex_rs2_data), 64'd0);
    check("rst_count", 64'(bypass_count), 64'd0);
    rst = 1'b0;
    idle();
    fire_valid = 1'b1;
    sched_pkt  = mk(5, 0, 3, 1, 0, 2);
    step();
    check("post_rst_valid", 64'(ex_valid), 64'd1);
    check("post_rst_rs1", 64'(ex_rs1_data), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
